matched_filter_mac: RTL and testbench

// - Complex matched-filter engine, directly downstream of the coefficient setup stage.
// - Captures the streamed complex impulse-response coefficients into a local tap store, then filters complex input samples.
// - One time-multiplexed complex multiplier-accumulator evaluates y[n] = sum_k x[n-k]*h[k], k = 0..TAPS-1.
// - Full-precision result goes to the downstream magnitude/threshold stage.

---
 rtl/mf_pkg.sv | 16 +
 rtl/matched_filter_mac_complex_mult.sv | 32 +++
 rtl/matched_filter_mac.sv | 138 +++++++++++++
 tb/tb_matched_filter_mac.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mf_pkg.sv
// rtl/mf_pkg.sv - shared state encoding and width helper for the matched filter
package mf_pkg;

    typedef enum logic [1:0] {
        LOAD_COEFF = 2'd0,
        READY      = 2'd1,
        MAC        = 2'd2,
        OUTPUT     = 2'd3
    } mf_state_e;

    // Full-precision result: complex product (2*DW+1) plus log2(TAPS) growth bits
    function automatic int mf_out_width(input int taps, input int data_width);
        return 2 * data_width + 1 + $clog2(taps);
    endfunction

endpackage

// File: rtl/matched_filter_mac_complex_mult.sv
// rtl/matched_filter_mac_complex_mult.sv - combinational signed complex multiply
module complex_mult #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_re,
    input  logic [DATA_WIDTH-1:0] a_im,
    input  logic [DATA_WIDTH-1:0] b_re,
    input  logic [DATA_WIDTH-1:0] b_im,
    output logic [2*DATA_WIDTH:0] p_re,
    output logic [2*DATA_WIDTH:0] p_im
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] ar_x, ai_x, br_x, bi_x;
    logic signed [PW-1:0] rr, ii, ri, ir;

    assign ar_x = $signed({{DATA_WIDTH{a_re[DATA_WIDTH-1]}}, a_re});
    assign ai_x = $signed({{DATA_WIDTH{a_im[DATA_WIDTH-1]}}, a_im});
    assign br_x = $signed({{DATA_WIDTH{b_re[DATA_WIDTH-1]}}, b_re});
    assign bi_x = $signed({{DATA_WIDTH{b_im[DATA_WIDTH-1]}}, b_im});

    assign rr = ar_x * br_x;
    assign ii = ai_x * bi_x;
    assign ri = ar_x * bi_x;
    assign ir = ai_x * br_x;

    // One extra bit: (-2^(DW-1))^2 summed twice needs it
    assign p_re = {rr[PW-1], rr} - {ii[PW-1], ii};
    assign p_im = {ri[PW-1], ri} + {ir[PW-1], ir};

endmodule

// File: rtl/matched_filter_mac.sv
// rtl/matched_filter_mac.sv - complex matched filter, one time-multiplexed complex MAC
module matched_filter_mac
    import mf_pkg::*;
#(
    parameter int TAPS       = 16,
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = mf_out_width(TAPS, DATA_WIDTH)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  coeffInValid,
    input  logic [DATA_WIDTH-1:0] coeffInRe,
    input  logic [DATA_WIDTH-1:0] coeffInIm,
    input  logic                  coeffSetFlag,
    input  logic                  dataInValid,
    input  logic [DATA_WIDTH-1:0] dataInRe,
    input  logic [DATA_WIDTH-1:0] dataInIm,
    output logic                  dataInReady,
    output logic                  dataOutValid,
    output logic [OUT_WIDTH-1:0]  dataOutRe,
    output logic [OUT_WIDTH-1:0]  dataOutIm,
    output logic                  coeffLoaded
);

    localparam int CW = $clog2(TAPS);
    localparam int PW = 2 * DATA_WIDTH + 1;

    mf_state_e state_q, state_d;

    logic [CW:0]             coeff_cnt_q;
    logic [CW-1:0]           tap_cnt_q;
    logic [DATA_WIDTH-1:0]   h_re_q [TAPS];
    logic [DATA_WIDTH-1:0]   h_im_q [TAPS];
    logic [DATA_WIDTH-1:0]   x_re_q [TAPS];
    logic [DATA_WIDTH-1:0]   x_im_q [TAPS];
    logic [OUT_WIDTH-1:0]    acc_re_q, acc_im_q;
    logic [OUT_WIDTH-1:0]    out_re_q, out_im_q;
    logic                    out_valid_q;
    logic                    coeff_loaded_q;
    logic                    ready;
    logic [PW-1:0]           prod_re, prod_im;

    complex_mult #(.DATA_WIDTH(DATA_WIDTH)) u_cmul (
        .a_re (x_re_q[tap_cnt_q]),
        .a_im (x_im_q[tap_cnt_q]),
        .b_re (h_re_q[tap_cnt_q]),
        .b_im (h_im_q[tap_cnt_q]),
        .p_re (prod_re),
        .p_im (prod_im)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_q <= LOAD_COEFF;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_COEFF: if (coeffSetFlag) state_d = READY;
            READY:      if (dataInValid) state_d = MAC;
            MAC:        if (tap_cnt_q == CW'(TAPS - 1)) state_d = OUTPUT;
            OUTPUT:     state_d = READY;
            default:    state_d = LOAD_COEFF;
        endcase
    end

    always_comb begin
        ready = (state_q == READY);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            coeff_cnt_q    <= '0;
            tap_cnt_q      <= '0;
            acc_re_q       <= '0;
            acc_im_q       <= '0;
            out_re_q       <= '0;
            out_im_q       <= '0;
            out_valid_q    <= 1'b0;
            coeff_loaded_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                h_re_q[k] <= '0;
                h_im_q[k] <= '0;
                x_re_q[k] <= '0;
                x_im_q[k] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                LOAD_COEFF: begin
                    // Counter saturates at TAPS so surplus coefficients are dropped
                    if (coeffInValid && !coeff_cnt_q[CW]) begin
                        h_re_q[coeff_cnt_q[CW-1:0]] <= coeffInRe;
                        h_im_q[coeff_cnt_q[CW-1:0]] <= coeffInIm;
                        coeff_cnt_q <= coeff_cnt_q + 1'b1;
                    end
                    if (coeffSetFlag) coeff_loaded_q <= 1'b1;
                end
                READY: begin
                    if (dataInValid) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            x_re_q[k] <= x_re_q[k-1];
                            x_im_q[k] <= x_im_q[k-1];
                        end
                        x_re_q[0] <= dataInRe;
                        x_im_q[0] <= dataInIm;
                        acc_re_q  <= '0;
                        acc_im_q  <= '0;
                        tap_cnt_q <= '0;
                    end
                end
                MAC: begin
                    acc_re_q  <= acc_re_q + {{(OUT_WIDTH-PW){prod_re[PW-1]}}, prod_re};
                    acc_im_q  <= acc_im_q + {{(OUT_WIDTH-PW){prod_im[PW-1]}}, prod_im};
                    tap_cnt_q <= tap_cnt_q + 1'b1;
                end
                OUTPUT: begin
                    out_re_q    <= acc_re_q;
                    out_im_q    <= acc_im_q;
                    out_valid_q <= 1'b1;
                end
                default: begin
                    out_re_q       <= '0;
                    out_im_q       <= '0;
                    coeff_loaded_q <= 1'b0;
                end
            endcase
        end
    end

    assign dataInReady  = ready;
    assign dataOutValid = out_valid_q;
    assign dataOutRe    = out_re_q;
    assign dataOutIm    = out_im_q;
    assign coeffLoaded  = coeff_loaded_q;

endmodule

// File: tb/tb_matched_filter_mac.sv
// tb/tb_matched_filter_mac.sv - directed self-checking bench for matched_filter_mac
module tb_matched_filter_mac;

    logic        clock;
    logic        resetN;
    logic        coeffInValid;
    logic [15:0] coeffInRe, coeffInIm;
    logic        coeffSetFlag;
    logic        dataInValid;
    logic [15:0] dataInRe, dataInIm;
    logic        dataInReady;
    logic        dataOutValid;
    logic [36:0] dataOutRe, dataOutIm;
    logic        coeffLoaded;

    int     tests;
    int     fails;
    int     hre [32];
    int     him [32];
    longint ore, oim;
    int     lat;
    bit     got;

    matched_filter_mac dut (
        .clock        (clock),
        .resetN       (resetN),
        .coeffInValid (coeffInValid),
        .coeffInRe    (coeffInRe),
        .coeffInIm    (coeffInIm),
        .coeffSetFlag (coeffSetFlag),
        .dataInValid  (dataInValid),
        .dataInRe     (dataInRe),
        .dataInIm     (dataInIm),
        .dataInReady  (dataInReady),
        .dataOutValid (dataOutValid),
        .dataOutRe    (dataOutRe),
        .dataOutIm    (dataOutIm),
        .coeffLoaded  (coeffLoaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        coeffInValid = 0; coeffInRe = 0; coeffInIm = 0; coeffSetFlag = 0;
        dataInValid = 0; dataInRe = 0; dataInIm = 0;
        resetN = 0;
        tick(); tick();
        resetN = 1;
        tick();
    endtask

    task automatic load(input int n, input bit flag_with_last);
        for (int k = 0; k < n; k++) begin
            coeffInValid = 1;
            coeffInRe = 16'(hre[k]);
            coeffInIm = 16'(him[k]);
            if (flag_with_last && k == n - 1) coeffSetFlag = 1;
            tick();
        end
        coeffInValid = 0;
        if (!flag_with_last) begin
            coeffSetFlag = 1;
            tick();
        end
        coeffSetFlag = 0;
    endtask

    task automatic send(input int re, input int im);
        int n;
        n = 0;
        while (!dataInReady && n < 100) begin tick(); n++; end
        dataInValid = 1;
        dataInRe = 16'(re);
        dataInIm = 16'(im);
        tick();
        dataInValid = 0;
        lat = 0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (dataOutValid) got = 1;
            else begin tick(); lat++; end
        end
        ore = longint'($signed(dataOutRe));
        oim = longint'($signed(dataOutIm));
        if (!got) begin
            tests++; fails++;
            $display("FAIL send_timeout: dataOutValid=%0b, required 1 within 100 cycles", dataOutValid);
        end
    endtask

    task automatic test_reset();
        resetN = 0;
        coeffInValid = 0; coeffInRe = 0; coeffInIm = 0; coeffSetFlag = 0;
        dataInValid = 1; dataInRe = 16'h1234; dataInIm = 16'h4321;
        tick(); tick();
        tests++;
        if (dataOutValid !== 1'b0 || dataOutRe !== 37'd0 || dataOutIm !== 37'd0 ||
            coeffLoaded !== 1'b0 || dataInReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b re=%0d im=%0d loaded=%0b ready=%0b, required all 0",
                     dataOutValid, dataOutRe, dataOutIm, coeffLoaded, dataInReady);
        end
        resetN = 1;
        got = 0;
        for (int i = 0; i < 5; i++) begin
            if (dataInReady) got = 1;
            tick();
        end
        tests++;
        if (got !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_load: dataInReady=%0b, required 0", got);
        end
        dataInValid = 0;
    endtask

    task automatic test_impulse();
        do_reset();
        for (int k = 0; k < 16; k++) begin hre[k] = k + 1; him[k] = 0; end
        load(16, 0);
        tests++;
        if (coeffLoaded !== 1'b1 || dataInReady !== 1'b1) begin
            fails++;
            $display("FAIL impulse_loaded: loaded=%0b ready=%0b, required 1 1", coeffLoaded, dataInReady);
        end
        for (int n = 0; n < 16; n++) begin
            send((n == 0) ? 1 : 0, 0);
            tests++;
            if (ore !== longint'(n + 1) || oim !== 64'sd0) begin
                fails++;
                $display("FAIL impulse_y%0d: re=%0d im=%0d, required re=%0d im=0", n, ore, oim, n + 1);
            end
        end
    endtask

    task automatic test_complex_product();
        do_reset();
        hre[0] = 0; him[0] = 1;
        load(1, 1);
        tests++;
        if (coeffLoaded !== 1'b1 || dataInReady !== 1'b1) begin
            fails++;
            $display("FAIL same_edge_load: loaded=%0b ready=%0b, required 1 1", coeffLoaded, dataInReady);
        end
        send(3, 4);
        tests++;
        if (ore !== -64'sd4 || oim !== 64'sd3) begin
            fails++;
            $display("FAIL complex_result: re=%0d im=%0d, required re=-4 im=3", ore, oim);
        end
        tests++;
        if (lat !== 17) begin
            fails++;
            $display("FAIL complex_latency: edges=%0d, required 17", lat);
        end
        tick();
        tests++;
        if (dataOutValid !== 1'b0 || $signed(dataOutRe) !== -37'sd4 || dataOutIm !== 37'd3) begin
            fails++;
            $display("FAIL valid_pulse_hold: valid=%0b re=%0d im=%0d, required 0 -4 3",
                     dataOutValid, $signed(dataOutRe), dataOutIm);
        end
    endtask

    task automatic test_short_load();
        do_reset();
        for (int k = 0; k < 4; k++) begin hre[k] = k + 1; him[k] = -(k + 1); end
        load(4, 0);
        for (int n = 0; n < 8; n++) begin
            send((n == 0) ? 1 : 0, 0);
            tests++;
            if (ore !== ((n < 4) ? longint'(n + 1) : 64'sd0) ||
                oim !== ((n < 4) ? -longint'(n + 1) : 64'sd0)) begin
                fails++;
                $display("FAIL short_load_y%0d: re=%0d im=%0d, required re=%0d im=%0d",
                         n, ore, oim, (n < 4) ? n + 1 : 0, (n < 4) ? -(n + 1) : 0);
            end
        end
    endtask

    task automatic test_long_load();
        do_reset();
        for (int k = 0; k < 20; k++) begin hre[k] = k + 1; him[k] = 100 + k; end
        load(20, 0);
        for (int n = 0; n < 16; n++) begin
            send((n == 0) ? 1 : 0, 0);
            tests++;
            if (ore !== longint'(n + 1) || oim !== longint'(100 + n)) begin
                fails++;
                $display("FAIL long_load_y%0d: re=%0d im=%0d, required re=%0d im=%0d",
                         n, ore, oim, n + 1, 100 + n);
            end
        end
    endtask

    task automatic test_extremes();
        do_reset();
        for (int k = 0; k < 16; k++) begin hre[k] = -32768; him[k] = -32768; end
        load(16, 0);
        for (int n = 0; n < 16; n++) begin
            send(-32768, -32768);
            if (n == 0 || n == 15) begin
                tests++;
                if (ore !== 64'sd0 || oim !== longint'(n + 1) * 64'sd2147483648) begin
                    fails++;
                    $display("FAIL extremes_y%0d: re=%0d im=%0d, required re=0 im=%0d",
                             n, ore, oim, longint'(n + 1) * 64'sd2147483648);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        int last;
        int bad_gap;
        do_reset();
        hre[0] = 1; him[0] = 0;
        load(1, 0);
        accepts = 0; last = -1; bad_gap = 0;
        dataInValid = 1; dataInRe = 16'd1; dataInIm = 16'd0;
        for (int i = 0; i < 56; i++) begin
            if (dataInReady) begin
                if (last >= 0 && i - last != 18) bad_gap = i - last;
                last = i;
                accepts++;
            end
            tick();
        end
        dataInValid = 0;
        tests++;
        if (accepts !== 4) begin
            fails++;
            $display("FAIL b2b_count: accepts=%0d, required 4", accepts);
        end
        tests++;
        if (bad_gap !== 0) begin
            fails++;
            $display("FAIL b2b_spacing: gap=%0d, required 18", bad_gap);
        end
    endtask

    task automatic test_mid_mac_reset();
        bit saw_valid;
        bit saw_ready;
        do_reset();
        hre[0] = 5; him[0] = 7;
        load(1, 0);
        dataInValid = 1; dataInRe = 16'd2; dataInIm = 16'd0;
        tick();
        dataInValid = 0;
        for (int i = 0; i < 5; i++) tick();
        resetN = 0;
        #1;
        tests++;
        if (dataOutValid !== 1'b0 || dataOutRe !== 37'd0 || dataOutIm !== 37'd0 ||
            coeffLoaded !== 1'b0 || dataInReady !== 1'b0) begin
            fails++;
            $display("FAIL midmac_reset_outputs: valid=%0b re=%0d im=%0d loaded=%0b ready=%0b, required all 0",
                     dataOutValid, dataOutRe, dataOutIm, coeffLoaded, dataInReady);
        end
        tick(); tick();
        resetN = 1;
        saw_valid = 0; saw_ready = 0;
        dataInValid = 1;
        for (int i = 0; i < 30; i++) begin
            if (dataOutValid) saw_valid = 1;
            if (dataInReady) saw_ready = 1;
            tick();
        end
        dataInValid = 0;
        tests++;
        if (saw_valid !== 1'b0 || saw_ready !== 1'b0) begin
            fails++;
            $display("FAIL midmac_no_output: valid_seen=%0b ready_seen=%0b, required 0 0", saw_valid, saw_ready);
        end
        load(1, 0);
        tests++;
        if (dataInReady !== 1'b1 || coeffLoaded !== 1'b1) begin
            fails++;
            $display("FAIL midmac_reload: ready=%0b loaded=%0b, required 1 1", dataInReady, coeffLoaded);
        end
        send(2, 0);
        tests++;
        if (ore !== 64'sd10 || oim !== 64'sd14) begin
            fails++;
            $display("FAIL midmac_after_reload: re=%0d im=%0d, required re=10 im=14", ore, oim);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_impulse();
        test_complex_product();
        test_short_load();
        test_long_load();
        test_extremes();
        test_back_to_back();
        test_mid_mac_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
